// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: fetch FSM states,
// AXI response codes and the NOP encoding used as the idle instruction.
package cpu_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned RESP_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'd0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'd2;
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'd3;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifu_axil_fetch.sv
// Single-outstanding instruction fetch: one AXI4-Lite read per request,
// result held toward decode until accepted. Flushed reads drain silently.
module ifu_axil_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_INST = DATA_WIDTH'(NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fault,
  output logic                  valid,
  input  logic                  ready
);

  fetch_state_e          r_state, w_state_nx;
  logic                  r_drop, w_drop_nx;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nx;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nx;
  logic [DATA_WIDTH-1:0] r_inst, w_inst_nx;
  logic                  r_fault, w_fault_nx;
  logic                  r_valid, r_arvalid, r_rready, r_req_ready;

  // Next-state and payload; handshake outputs follow directly from next state.
  always_comb begin
    w_state_nx  = r_state;
    w_drop_nx   = r_drop;
    w_pc_nx     = r_pc;
    w_araddr_nx = r_araddr;
    w_inst_nx   = r_inst;
    w_fault_nx  = r_fault;
    unique case (r_state)
      ST_IDLE: begin
        if (!flush && req_valid) begin
          w_pc_nx     = req_pc;
          w_araddr_nx = req_pc;
          if (req_pc[1:0] != 2'b00) begin
            w_state_nx = ST_HOLD;
            w_fault_nx = 1'b1;
            w_inst_nx  = RESET_INST;
          end else begin
            w_state_nx = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        // An issued AR cannot be withdrawn; remember to discard its beat.
        if (flush)   w_drop_nx  = 1'b1;
        if (arready) w_state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (flush) w_drop_nx = 1'b1;
        if (rvalid) begin
          if (r_drop || flush) begin
            w_state_nx = ST_IDLE;
            w_drop_nx  = 1'b0;
          end else begin
            w_state_nx = ST_HOLD;
            w_fault_nx = (rresp != RESP_OKAY);
            w_inst_nx  = (rresp != RESP_OKAY) ? RESET_INST : rdata;
          end
        end
      end
      ST_HOLD: begin
        if (flush || ready) begin
          w_state_nx = ST_IDLE;
          w_fault_nx = 1'b0;
          w_inst_nx  = RESET_INST;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drop      <= 1'b0;
      r_pc        <= '0;
      r_araddr    <= '0;
      r_inst      <= RESET_INST;
      r_fault     <= 1'b0;
      r_valid     <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_drop      <= w_drop_nx;
      r_pc        <= w_pc_nx;
      r_araddr    <= w_araddr_nx;
      r_inst      <= w_inst_nx;
      r_fault     <= w_fault_nx;
      r_valid     <= (w_state_nx == ST_HOLD);
      r_arvalid   <= (w_state_nx == ST_ADDR);
      r_rready    <= (w_state_nx == ST_DATA);
      r_req_ready <= (w_state_nx == ST_IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign araddr    = r_araddr;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign inst      = r_inst;
  assign pc        = r_pc;
  assign fault     = r_fault;
  assign valid     = r_valid;

  // A read beat outside the data phase is a slave protocol violation.
  a_rvalid_in_data: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (r_state == ST_DATA));

endmodule

// File: tb/tb_ifu_axil_fetch.sv
// Directed bench for ifu_axil_fetch: the bench plays both the PC logic and
// the AXI-Lite slave, stepping cycle by cycle with hand-computed expectations.
module tb_ifu_axil_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fault;
  logic        valid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  ifu_axil_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .inst(inst), .pc(pc), .fault(fault),
    .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch from request cycle through to the first HOLD cycle.
  task automatic fetch_to_hold(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs);
    req_valid = 1'b1; req_pc = a; arready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rvalid = 1'b1; rdata = d; rresp = rs;
    tick();
    rvalid = 1'b0; rresp = RESP_OKAY;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; arready = 1'b0;
    rdata = '0; rresp = RESP_OKAY; rvalid = 1'b0; ready = 1'b1;
    tick(); tick();
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk32("rst_inst", inst, 32'h0000_0013);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_araddr", araddr, 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait slave: arvalid T+1, rvalid at T+2, valid at T+3.
    req_valid = 1'b1; req_pc = 32'h8000_0000; arready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk1("zw_arvalid", arvalid, 1'b1);
    chk32("zw_araddr", araddr, 32'h8000_0000);
    chk1("zw_req_ready_busy", req_ready, 1'b0);
    tick();
    chk1("zw_rready", rready, 1'b1);
    chk1("zw_arvalid_drop", arvalid, 1'b0);
    chk1("zw_valid_early", valid, 1'b0);
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick();
    rvalid = 1'b0;
    chk1("zw_valid", valid, 1'b1);
    chk32("zw_inst", inst, 32'h0010_0093);
    chk32("zw_pc", pc, 32'h8000_0000);
    chk1("zw_fault", fault, 1'b0);
    tick();
    chk1("zw_valid_one_cycle", valid, 1'b0);
    chk1("zw_req_ready_back", req_ready, 1'b1);
    chk32("zw_inst_idle_nop", inst, 32'h0000_0013);

    // Decode backpressure.
    ready = 1'b0;
    fetch_to_hold(32'h8000_0004, 32'h0000_0513, RESP_OKAY);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid_held", valid, 1'b1);
      chk32("bp_inst_held", inst, 32'h0000_0513);
      chk32("bp_pc_held", pc, 32'h8000_0004);
      chk1("bp_req_ready_low", req_ready, 1'b0);
      tick();
    end
    ready = 1'b1;
    tick();
    chk1("bp_valid_drop", valid, 1'b0);
    chk1("bp_req_ready", req_ready, 1'b1);

    // Slave wait states: 3 cycles of arready low, 4 cycles without rvalid.
    arready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h8000_0008;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("ws_arvalid_stable", arvalid, 1'b1);
      chk32("ws_araddr_stable", araddr, 32'h8000_0008);
      tick();
    end
    chk1("ws_arvalid_still", arvalid, 1'b1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("ws_no_second_ar", arvalid, 1'b0);
      chk1("ws_rready", rready, 1'b1);
      chk1("ws_valid_wait", valid, 1'b0);
      tick();
    end
    rvalid = 1'b1; rdata = 32'h00A0_0113;
    tick();
    rvalid = 1'b0;
    chk1("ws_valid", valid, 1'b1);
    chk32("ws_inst", inst, 32'h00A0_0113);
    chk32("ws_pc", pc, 32'h8000_0008);
    tick();
    chk1("ws_single_valid", valid, 1'b0);
    chk1("ws_arvalid_after", arvalid, 1'b0);

    // Error response replaces the data with the NOP.
    fetch_to_hold(32'h8000_000C, 32'hDEAD_BEEF, RESP_SLVERR);
    chk1("err_valid", valid, 1'b1);
    chk1("err_fault", fault, 1'b1);
    chk32("err_inst", inst, 32'h0000_0013);
    tick();
    chk1("err_valid_drop", valid, 1'b0);
    chk1("err_fault_clear", fault, 1'b0);

    // Misaligned PC never touches the bus.
    arready = 1'b1;
    req_valid = 1'b1; req_pc = 32'h8000_0002;
    tick();
    req_valid = 1'b0;
    chk1("mis_no_arvalid", arvalid, 1'b0);
    chk1("mis_valid", valid, 1'b1);
    chk1("mis_fault", fault, 1'b1);
    chk32("mis_inst", inst, 32'h0000_0013);
    chk32("mis_pc", pc, 32'h8000_0002);
    tick();
    chk1("mis_no_arvalid_2", arvalid, 1'b0);
    chk1("mis_valid_drop", valid, 1'b0);

    // Flush in DATA: late beat is swallowed, no valid pulse.
    req_valid = 1'b1; req_pc = 32'h8000_0010;
    tick();
    req_valid = 1'b0;
    tick();
    chk1("fd_in_data", rready, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fd_rready_drain", rready, 1'b1);
    chk1("fd_req_ready_low", req_ready, 1'b0);
    chk1("fd_valid_none", valid, 1'b0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    chk1("fd_valid_after_beat", valid, 1'b0);
    chk1("fd_idle", req_ready, 1'b1);
    chk1("fd_rready_off", rready, 1'b0);
    fetch_to_hold(32'h8000_0004, 32'h0040_0193, RESP_OKAY);
    chk1("fd_next_valid", valid, 1'b1);
    chk32("fd_next_inst", inst, 32'h0040_0193);
    chk32("fd_next_pc", pc, 32'h8000_0004);
    tick();

    // Flush in ADDR: AR stays up until accepted, then the beat is dropped.
    arready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h8000_0020;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fa_arvalid_kept", arvalid, 1'b1);
    chk32("fa_araddr_kept", araddr, 32'h8000_0020);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk1("fa_rready", rready, 1'b1);
    chk1("fa_req_ready_low", req_ready, 1'b0);
    rvalid = 1'b1; rdata = 32'hCAFE_0001;
    tick();
    rvalid = 1'b0;
    chk1("fa_no_valid", valid, 1'b0);
    chk1("fa_idle", req_ready, 1'b1);

    // Flush beats a simultaneous request in IDLE.
    req_valid = 1'b1; req_pc = 32'h8000_0030; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk1("fi_not_accepted", arvalid, 1'b0);
    chk1("fi_still_idle", req_ready, 1'b1);
    chk1("fi_valid", valid, 1'b0);

    // Flush in HOLD drops the held instruction.
    ready = 1'b0;
    fetch_to_hold(32'h8000_0040, 32'h0050_0213, RESP_OKAY);
    chk1("fh_valid", valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; ready = 1'b1;
    chk1("fh_valid_drop", valid, 1'b0);
    chk1("fh_req_ready", req_ready, 1'b1);

    // Asynchronous reset while in ADDR.
    arready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h8000_0050;
    tick();
    req_valid = 1'b0;
    chk1("ar_in_addr", arvalid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("ar_arvalid", arvalid, 1'b0);
    chk1("ar_req_ready", req_ready, 1'b1);
    chk32("ar_araddr", araddr, 32'h0);
    chk32("ar_pc", pc, 32'h0);
    chk32("ar_inst", inst, 32'h0000_0013);
    chk1("ar_valid", valid, 1'b0);
    chk1("ar_rready", rready, 1'b0);
    rst = 1'b0;
    tick();
    chk1("ar_idle_after", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
